// File: rtl/inst_mem_loader.sv
// Boot-time instruction-memory loader: framed byte stream in, word writes out,
// core held in reset until a checksum-verified image has been written.
module inst_mem_loader #(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned MEM_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [MEM_WIDTH-1:0] mem_wdata,
  output logic                 cpu_rst,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    CHK,
    DONE,
    ERR
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [15:0] count;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_q;
  logic [7:0]  csum;

  logic        xfer;
  logic        begin_load;
  logic [15:0] count_full;
  logic [15:0] idx_inc;
  logic        last_word;

  assign xfer       = in_valid && in_ready;
  assign begin_load = start && (state == IDLE || state == DONE || state == ERR);
  assign count_full = {in_data, count[7:0]};
  assign idx_inc    = word_idx + 16'd1;
  assign last_word  = (byte_cnt == 2'd3) && (idx_inc == count);

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) state_next = HDR0;
      end
      HDR0: begin
        if (xfer) state_next = HDR1;
      end
      HDR1: begin
        if (xfer) begin
          if ({16'b0, count_full} > MEM_DEPTH) state_next = ERR;
          else if (count_full == 16'd0)         state_next = CHK;
          else                                  state_next = DATA;
        end
      end
      DATA: begin
        if (xfer && last_word) state_next = CHK;
      end
      CHK: begin
        if (xfer) state_next = (in_data == csum) ? DONE : ERR;
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are flopped from the next state so they carry no
  // combinational path from the handshake inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      cpu_rst  <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next == HDR0) || (state_next == HDR1) ||
                  (state_next == DATA) || (state_next == CHK);
      cpu_rst  <= (state_next == DONE);
      done     <= (state_next == DONE);
      error    <= (state_next == ERR);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      word_idx  <= '0;
      byte_cnt  <= '0;
      asm_q     <= '0;
      csum      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (begin_load) begin
        count    <= '0;
        word_idx <= '0;
        byte_cnt <= '0;
        asm_q    <= '0;
        csum     <= '0;
      end else if (xfer) begin
        case (state)
          HDR0: count[7:0]  <= in_data;
          HDR1: count[15:8] <= in_data;
          DATA: begin
            csum     <= csum ^ in_data;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: asm_q[7:0]   <= in_data;
              2'd1: asm_q[15:8]  <= in_data;
              2'd2: asm_q[23:16] <= in_data;
              default: begin
                mem_we    <= 1'b1;
                mem_wdata <= {in_data, asm_q};
                mem_addr  <= BASE_ADDR + {14'b0, word_idx, 2'b00};
                word_idx  <= idx_inc;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: frame-level reference model checked every cycle
// against two instances (base 0x000 and 0x100), plus directed literal checks.
module tb_inst_mem_loader;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;

  logic        r0, we0, cr0, dn0, er0;
  logic [31:0] addr0, wd0;
  logic        r1, we1, cr1, dn1, er1;
  logic [31:0] addr1, wd1;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  logic [31:0] log_a[$];
  logic [31:0] log_d[$];
  logic [31:0] log_a1[$];

  always #5 clk = ~clk;

  inst_mem_loader #(.MEM_DEPTH(1024), .MEM_WIDTH(32), .BASE_ADDR(32'h0000_0000)) u0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(r0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
    .cpu_rst(cr0), .done(dn0), .error(er0)
  );

  inst_mem_loader #(.MEM_DEPTH(1024), .MEM_WIDTH(32), .BASE_ADDR(32'h0000_0100)) u1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(r1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
    .cpu_rst(cr1), .done(dn1), .error(er1)
  );

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 'x;
  endfunction

  // Reference model: tracks position inside the frame, not the RTL's FSM.
  bit          m_active;
  int          m_pos;
  int          m_n;
  int          m_result;   // 0 none, 1 good image, 2 failed
  logic [7:0]  m_xor;
  logic [31:0] m_word;
  bit          e_we;
  logic [31:0] e_addr0, e_addr1, e_wdata;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 0; m_pos = 0; m_n = 0; m_result = 0;
      m_xor = 0; m_word = 0; e_we = 0;
      e_addr0 = 0; e_addr1 = 0; e_wdata = 0;
    end else begin
      e_we = 0;
      if (!m_active) begin
        if (start) begin
          m_active = 1; m_pos = 0; m_n = 0; m_xor = 0; m_result = 0;
        end
      end else if (in_valid) begin
        if (m_pos == 0) begin
          m_n = int'(in_data);
          m_pos = 1;
        end else if (m_pos == 1) begin
          m_n = m_n + int'(in_data) * 256;
          m_pos = 2;
          if (m_n > 1024) begin
            m_active = 0; m_result = 2;
          end
        end else if (m_pos < 2 + 4 * m_n) begin
          int k;
          k = m_pos - 2;
          m_word[8*(k%4) +: 8] = in_data;
          m_xor = m_xor ^ in_data;
          if (k % 4 == 3) begin
            e_we = 1;
            e_wdata = m_word;
            e_addr0 = 32'(4 * (k / 4));
            e_addr1 = 32'h100 + 32'(4 * (k / 4));
          end
          m_pos++;
        end else begin
          m_active = 0;
          m_result = (in_data == m_xor) ? 1 : 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      logic mdone, merr;
      mdone = !m_active && m_result == 1;
      merr  = !m_active && m_result == 2;
      chk("ctl0", {r0, we0, cr0, dn0, er0}, {m_active, e_we, mdone, mdone, merr});
      chk("addr0", addr0, e_addr0);
      chk("wdata0", wd0, e_wdata);
      chk("ctl1", {r1, we1, cr1, dn1, er1}, {m_active, e_we, mdone, mdone, merr});
      chk("addr1", addr1, e_addr1);
      chk("wdata1", wd1, e_wdata);
      if (we0) begin
        log_a.push_back(addr0);
        log_d.push_back(wd0);
      end
      if (we1) log_a1.push_back(addr1);
    end
  end

  task automatic clear_logs;
    log_a.delete(); log_d.delete(); log_a1.delete();
  endtask

  task automatic pulse_start;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the last byte transfers.
  // gap: 0 = valid held high, 1 = valid toggles every cycle, 2 = random.
  task automatic send(input bq_t bytes, input int gap, input int start_at);
    bit tog;
    tog = 1'b1;
    foreach (bytes[i]) begin
      bit acc;
      int budget;
      acc = 0;
      budget = 0;
      while (!acc) begin
        logic v, rdy;
        if (budget > 40) begin
          checks++; failures++;
          $display("FAIL send_timeout byte=%0d got=not_accepted want=accepted", i);
          in_valid = 1'b0; start = 1'b0;
          return;
        end
        case (gap)
          0: v = 1'b1;
          1: begin v = tog; tog = ~tog; end
          default: v = 1'($urandom % 2);
        endcase
        in_valid = v;
        in_data  = v ? bytes[i] : 8'($urandom);
        start    = (i == start_at) && v;
        rdy = r0;
        @(posedge clk);
        acc = rdy && v;
        @(negedge clk);
        budget++;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic chk_nominal_writes(input string tag);
    chk({tag, "_nwr"}, log_a.size(), 2);
    chk({tag, "_a0"}, qget(log_a, 0), 32'h0);
    chk({tag, "_d0"}, qget(log_d, 0), 32'h0050_0093);
    chk({tag, "_a1"}, qget(log_a, 1), 32'h4);
    chk({tag, "_d1"}, qget(log_d, 1), 32'h00A0_0113);
    chk({tag, "_base100"}, qget(log_a1, 0), 32'h100);
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    bq_t nom, bad, part, q;
    nom = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
    bad = nom;
    bad[10] = 8'h70;
    for (int i = 0; i < 6; i++) part.push_back(nom[i]);

    #12;
    chk("reset_u0", {r0, we0, cr0, dn0, er0, addr0, wd0}, '0);
    chk("reset_u1", {r1, we1, cr1, dn1, er1, addr1, wd1}, '0);
    @(negedge clk); rst = 1'b1; check_en = 1'b1;
    repeat (2) @(negedge clk);

    clear_logs();
    pulse_start();
    send(nom, 0, -1);
    repeat (3) @(negedge clk);
    chk("nom_status", {dn0, cr0, er0, r0}, 4'b1100);
    chk_nominal_writes("nom");

    // restart from DONE, with a start pulse dropped into the DATA phase
    clear_logs();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("restart_status", {cr0, dn0, r0}, 3'b001);
    send(bad, 0, 6);
    repeat (3) @(negedge clk);
    chk("bad_status", {er0, dn0, cr0}, 3'b100);
    chk("bad_nwr", log_a.size(), 2);

    clear_logs();
    pulse_start();
    q = '{8'h01, 8'h04};
    send(q, 0, -1);
    chk("over_status", {er0, r0, dn0}, 3'b100);
    repeat (3) @(negedge clk);
    chk("over_nwr", log_a.size(), 0);

    clear_logs();
    pulse_start();
    q = '{8'h00, 8'h00, 8'h00};
    send(q, 0, -1);
    repeat (2) @(negedge clk);
    chk("zero_status", {dn0, cr0, er0}, 3'b110);
    chk("zero_nwr", log_a.size(), 0);

    clear_logs();
    pulse_start();
    send(nom, 1, -1);
    repeat (3) @(negedge clk);
    chk("bp_status", {dn0, er0}, 2'b10);
    chk_nominal_writes("bp");

    pulse_start();
    send(part, 0, -1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_u0", {r0, we0, cr0, dn0, er0, addr0, wd0}, '0);
    chk("midrst_u1", {r1, we1, cr1, dn1, er1, addr1, wd1}, '0);
    @(negedge clk); rst = 1'b1;
    clear_logs();
    pulse_start();
    send(nom, 0, -1);
    repeat (3) @(negedge clk);
    chk_nominal_writes("after_rst");

    for (int f = 0; f < 24; f++) begin
      int n;
      bit over, good;
      logic [7:0] x;
      over = ($urandom % 6) == 0;
      n = over ? 1025 + int'($urandom_range(0, 300)) : int'($urandom_range(0, 5));
      good = !over && (($urandom % 4) != 0);
      q.delete();
      q.push_back(8'(n));
      q.push_back(8'(n >> 8));
      x = 8'h00;
      if (!over) begin
        for (int b = 0; b < 4 * n; b++) begin
          logic [7:0] d;
          d = 8'($urandom);
          x = x ^ d;
          q.push_back(d);
        end
        q.push_back(good ? x : (x ^ 8'(1 + $urandom_range(0, 254))));
      end
      clear_logs();
      pulse_start();
      send(q, int'($urandom_range(0, 2)), int'($urandom_range(0, 8)));
      repeat (2) @(negedge clk);
      chk("rnd_result", {dn0, er0}, {good, !good});
      chk("rnd_nwr", log_a.size(), over ? 0 : n);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Boot-time writer for the instruction memory, the write-side counterpart of the single-cycle core's instruction ROM.
- Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instructions.
- Issues single-cycle write strobes at PC-style byte addresses (word-aligned, +4 per instruction).
- Holds the core in reset until a checksum-verified image has been loaded.

Parameters:
- MEM_DEPTH, 1024: instruction memory depth in words; largest legal word count.
- MEM_WIDTH, 32: instruction width in bits; fixed at 32 (4 bytes per word).
- BASE_ADDR, 32'h0000_0000: byte address of the first word; must be 4-aligned.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load (honoured in IDLE, DONE, ERR only).
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader can accept a byte; a byte transfers when in_valid && in_ready at a clk rising edge.
- mem_we  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr  output  32  byte address of the write; BASE_ADDR + 4*index.
- mem_wdata  output  32  instruction word to write.
- cpu_rst  output  1  active-low reset for the core; high only in DONE.
- done  output  1  image loaded and checksum matched (level, DONE state).
- error  output  1  load failed (level, ERR state).

Behaviour:
- Reset (rst low, asynchronous): state=IDLE.
  - Outputs: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=0, done=0, error=0.
  - Internal: byte counter, word index, count, checksum and assembly register all cleared.
- Frame format, in order:
  - 2 count bytes, LSB first (N, 16-bit).
  - N*4 data bytes, each word LSB first.
  - 1 checksum byte = XOR of all data bytes (header excluded; N=0 means checksum 0x00).
- States: IDLE, HDR0, HDR1, DATA, CHK, DONE, ERR.
- in_ready is 1 in HDR0/HDR1/DATA/CHK and 0 in IDLE/DONE/ERR. It is registered from the state only, with no combinational path from in_valid.
- IDLE/DONE/ERR + start -> HDR0. Entering HDR0 clears the checksum, word index, byte counter, done and error, and drives cpu_rst=0.
- start while in HDR0..CHK is ignored.
- HDR0: on transfer, count[7:0]=in_data -> HDR1.
- HDR1: on transfer, count[15:8]=in_data. Then:
  - N > MEM_DEPTH -> ERR.
  - N == 0 -> CHK.
  - else -> DATA.
- DATA: each transfer shifts in_data into byte lane byte_cnt (0..3) and XORs it into the checksum.
  - When the 4th byte transfers, the next cycle has mem_we=1 for exactly one cycle, mem_wdata=assembled word, mem_addr=BASE_ADDR+4*index.
  - index then increments. After the word with index N-1 -> CHK.
  - Write latency: strobe is 1 cycle after the last byte's acceptance edge.
  - in_ready stays high during the strobe cycle; back-to-back bytes never stall.
- mem_addr and mem_wdata hold their last written values when mem_we=0.
- CHK: on transfer:
  - in_data == checksum -> DONE (done=1, cpu_rst=1).
  - else -> ERR (error=1, cpu_rst=0).
- The last data word's mem_we pulse may coincide with the CHK state; this is legal.
- Arithmetic: index is 16-bit. Address = BASE_ADDR + {index,2'b00}, truncated to 32 bits. No wrap occurs because N ≤ MEM_DEPTH.
- in_valid low: no state change, no checksum update.
- Reset asserted mid-load: immediate return to IDLE, mem_we drops at once, and any partially assembled word is discarded (never written).
- cpu_rst is never high except in DONE. A restart from DONE drops cpu_rst in the first HDR0 cycle.

Test Plan:
- Nominal load: after reset, pulse start, stream 02 00 93 00 50 00 13 01 A0 00 71 with in_valid held high.
  - Required: exactly two mem_we pulses: addr 0x0 data 0x00500093, then addr 0x4 data 0x00A00113.
  - Required: done=1, cpu_rst=1, error=0, in_ready=0.
- Bad checksum: same stream with final byte 0x70.
  - Required: both writes still occur; error=1, done=0, cpu_rst=0.
- Oversize count: count bytes 01 04 (N=1025) with MEM_DEPTH=1024.
  - Required: ERR right after the 2nd header byte, no mem_we, in_ready=0.
- Zero-word image and backpressure:
  - Stream 00 00 00 -> DONE with no writes.
  - Then nominal stream with in_valid toggling every other cycle -> identical writes and addresses to the nominal case.
- Mid-load reset: assert rst low after the 6th byte of the nominal stream.
  - Required: outputs return to reset values asynchronously.
  - Required: a subsequent start plus full stream produces writes at 0x0 and 0x4 with correct data.
- Start handling:
  - start pulse during DATA is ignored.
  - start in DONE restarts: cpu_rst=0 and done=0 in the next cycle, and BASE_ADDR=0x100 yields first write at 0x100.
